shared_output_arbiter: RTL

- Time-shares one output resource (an actuator channel) between four requesters.
- Grants exclusive ownership to one requester at a time.
- Enforces a maximum hold time per grant and an idle gap between grants.
- Sits between the ui_in request decode and the controller FSM; drives the grant that selects which requester's command the FSM consumes.

---
 rtl/shared_output_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/shared_output_arbiter.sv
// Four-way time-sharing arbiter for one actuator channel: urgent-first round-robin
// grant with a bounded hold time and an idle gap after every grant.
module shared_output_arbiter #(
  parameter int MAX_HOLD   = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] req,
  input  logic [3:0] urgent,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gntId_q, gntId_d;
  logic [1:0] last_q, last_d;
  logic [7:0] holdCnt_q, holdCnt_d;
  logic [3:0] gapCnt_q, gapCnt_d;

  logic [3:0] candSet;
  logic [1:0] scanIdx;
  logic [1:0] winner;
  logic       found;
  logic       ownerRelease;
  logic       atLimit;
  logic       timeoutPulse;

  // Urgent requests form their own tier; the rotating scan starts just after the last owner.
  always_comb begin
    candSet = ((req & urgent) != 4'b0000) ? (req & urgent) : req;
    winner  = last_q;
    found   = 1'b0;
    scanIdx = last_q;
    for (int k = 1; k <= 4; k++) begin
      scanIdx = last_q + 2'(k);
      if (!found && candSet[scanIdx]) begin
        winner = scanIdx;
        found  = 1'b1;
      end
    end
  end

  assign ownerRelease = done[gntId_q] | ~req[gntId_q];
  assign atLimit      = (holdCnt_q == HOLD_LAST);

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gntId_d      = gntId_q;
    last_d       = last_q;
    holdCnt_d    = holdCnt_q;
    gapCnt_d     = gapCnt_q;
    timeoutPulse = 1'b0;
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (req != 4'b0000) begin
            state_d   = GRANT;
            gnt_d     = 4'b0001 << winner;
            gntId_d   = winner;
            last_d    = winner;
            holdCnt_d = 8'd0;
          end
        end
        GRANT: begin
          // A release in the limit cycle wins, so the timer only fires when the owner hangs on.
          if (ownerRelease || atLimit) begin
            gnt_d        = 4'b0000;
            holdCnt_d    = 8'd0;
            gapCnt_d     = 4'd0;
            timeoutPulse = ~ownerRelease;
            state_d      = (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            holdCnt_d = holdCnt_q + 8'd1;
          end
        end
        GAP: begin
          if (gapCnt_q == GAP_LAST) begin
            state_d  = IDLE;
            gapCnt_d = 4'd0;
          end else begin
            gapCnt_d = gapCnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      gntId_q   <= 2'd0;
      last_q    <= 2'd3;
      holdCnt_q <= 8'd0;
      gapCnt_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gntId_q   <= gntId_d;
      last_q    <= last_d;
      holdCnt_q <= holdCnt_d;
      gapCnt_q  <= gapCnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gntId_q;
  assign busy    = (state_q != IDLE);
  assign timeout = timeoutPulse;

  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));

endmodule
